// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: WB, MU and register-file write-port signals of the write arbiter
interface rf_wr_arbiter_if;
  logic        wb_req;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        mu_valid;
  logic        mu_ready;
  logic [4:0]  mu_waddr;
  logic [31:0] mu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic [1:0]  mu_cnt;
  modport master (
    output wb_req, wb_waddr, wb_wdata, mu_valid, mu_waddr, mu_wdata,
    input  wb_stall, mu_ready, rf_we, rf_waddr, rf_wdata, rf_src, mu_cnt
  );
  modport slave (
    input  wb_req, wb_waddr, wb_wdata, mu_valid, mu_waddr, mu_wdata,
    output wb_stall, mu_ready, rf_we, rf_waddr, rf_wdata, rf_src, mu_cnt
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: one RF write port shared by WB and a 2-entry MU result FIFO; RF_ARB_STARVE_GUARD_EN adds the MU starvation guard
module rf_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            resetn,
  rf_wr_arbiter_if.slave bus
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  logic [36:0] mem [2];
  logic        wp, rp;
  logic [1:0]  cnt;
  logic        empty, push, store, wb_gnt, pop;
  logic [36:0] head;
  assign empty = cnt == 2'd0;
  assign head = mem[rp];
  assign bus.mu_cnt = cnt;
  assign bus.mu_ready = resetn && cnt != 2'd2;
  assign push = bus.mu_valid && bus.mu_ready;
  // results for r0 are acknowledged to the MU but never occupy a slot
  assign store = push && bus.mu_waddr != 5'd0;
`ifdef RF_ARB_STARVE_GUARD_EN
  logic [3:0] age;
  assign bus.wb_stall = resetn && !empty && age >= 4'(STARVE_LIMIT);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) age <= '0;
    else age <= (pop || empty) ? 4'd0 : (age == 4'hf ? age : age + 4'd1);
`else
  assign bus.wb_stall = 1'b0;
`endif
  assign wb_gnt = bus.wb_req && !bus.wb_stall;
  assign pop = resetn && !wb_gnt && !empty;
  assign bus.rf_src = pop;
  assign bus.rf_waddr = pop ? head[36:32] : bus.wb_waddr;
  assign bus.rf_wdata = pop ? head[31:0] : bus.wb_wdata;
  assign bus.rf_we = resetn && (wb_gnt || pop) && bus.rf_waddr != 5'd0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp  <= wp ^ store;
      rp  <= rp ^ pop;
      cnt <= cnt + 2'(store) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (store) mem[wp] <= {bus.mu_waddr, bus.mu_wdata};
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: random and directed stimulus checked against a queue-based model of the write arbiter
module tb_rf_wr_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int nvec = 0;
  int nerr = 0;
  logic [36:0] q[$];
  int age = 0;
  rf_wr_arbiter_if bus();
  rf_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [4:0] wa, input logic [31:0] wd,
                     input logic v, input logic [4:0] ma, input logic [31:0] md);
    logic stall, gnt, pp, rdy, we;
    logic [4:0] ea;
    logic [31:0] ed;
    bus.wb_req = r;
    bus.wb_waddr = wa;
    bus.wb_wdata = wd;
    bus.mu_valid = v;
    bus.mu_waddr = ma;
    bus.mu_wdata = md;
    @(negedge clk);
    rdy = q.size() < 2;
`ifdef RF_ARB_STARVE_GUARD_EN
    stall = q.size() > 0 && age >= LIMIT;
`else
    stall = 1'b0;
`endif
    gnt = r && !stall;
    pp = !gnt && q.size() > 0;
    ea = wa;
    ed = wd;
    if (pp) begin
      ea = q[0][36:32];
      ed = q[0][31:0];
    end
    we = (gnt || pp) && ea != 5'd0;
    chk("wb_stall", 64'(bus.wb_stall), 64'(stall));
    chk("mu_ready", 64'(bus.mu_ready), 64'(rdy));
    chk("mu_cnt", 64'(bus.mu_cnt), 64'(q.size()));
    chk("rf_we", 64'(bus.rf_we), 64'(we));
    chk("rf_src", 64'(bus.rf_src), 64'(pp));
    if (gnt || pp) begin
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(ea));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(ed));
    end
    age = (pp || q.size() == 0) ? 0 : (age < 15 ? age + 1 : 15);
    if (pp) void'(q.pop_front());
    if (v && rdy && ma != 5'd0) q.push_back({ma, md});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    bus.wb_req = 1'b1;
    bus.wb_waddr = 5'd3;
    bus.mu_valid = 1'b1;
    bus.mu_waddr = 5'd6;
    resetn = 1'b0;
    #1;
    chk("rst_mu_cnt", 64'(bus.mu_cnt), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_mu_ready", 64'(bus.mu_ready), 64'd0);
    chk("rst_wb_stall", 64'(bus.wb_stall), 64'd0);
    q.delete();
    age = 0;
    @(negedge clk);
    bus.wb_req = 1'b0;
    bus.mu_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_mu_ready", 64'(bus.mu_ready), 64'd1);
  endtask
  initial begin
    logic [4:0] a;
    bus.wb_req = 1'b0;
    bus.wb_waddr = '0;
    bus.wb_wdata = '0;
    bus.mu_valid = 1'b0;
    bus.mu_waddr = '0;
    bus.mu_wdata = '0;
    #1;
    do_reset();
    cyc(1, 5, 32'h1234, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 32'hAA);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h1, 1, 9, 32'h11);
    cyc(1, 4, 32'h2, 1, 10, 32'h22);
    cyc(1, 8, 32'h3, 1, 11, 32'h33);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 2, 32'h5, 1, 12, 32'h44);
    for (int i = 0; i < 7; i++) cyc(1, 5'(13 + i), 32'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h55);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'hdead, 0, 0, 0);
    cyc(1, 1, 32'h6, 1, 20, 32'h66);
    cyc(1, 1, 32'h7, 1, 21, 32'h77);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
          $urandom_range(0, 2) == 0, a, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
